// File: rtl/lsu.sv
// Load/store unit: accepts one memory op from EX, issues a single
// word-aligned request on the data-memory channel, formats store data and
// byte enables, extracts/extends load data, and reports completion or a
// misaligned-address exception with a one-cycle response pulse.
module lsu (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] rdata_o,
  output logic        misaligned_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} state_t;

  state_t      state, state_next;

  logic        accept;
  logic        is_word, is_half, misaligned;
  logic [3:0]  be_fmt;
  logic [31:0] wdata_fmt;
  logic [31:0] byte_shift;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  logic        store_q, zext_q, half_q, word_q, mis_q;
  logic [1:0]  lane_q;
  logic [29:0] waddr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q, rdata_q;

  assign accept = req_valid_i && req_ready_o;

  // Decode size, alignment, store lanes and replicated store data.
  // funct3[1] set means word, which also covers the 011/110/111 encodings.
  always_comb begin
    is_word    = funct3_i[1];
    is_half    = !funct3_i[1] && funct3_i[0];
    misaligned = (is_half && addr_i[0]) || (is_word && (addr_i[1:0] != 2'b00));
    be_fmt     = '1;
    wdata_fmt  = '0;
    if (is_store_i) begin
      if (is_word) begin
        be_fmt    = '1;
        wdata_fmt = wdata_i;
      end else if (is_half) begin
        be_fmt    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_fmt = {2{wdata_i[15:0]}};
      end else begin
        be_fmt    = 4'b0001 << addr_i[1:0];
        wdata_fmt = {4{wdata_i[7:0]}};
      end
    end
  end

  // Extract the addressed lane from the returned word and extend it.
  always_comb begin
    byte_shift = mem_rdata_i >> {lane_q, 3'b000};
    half_sel   = lane_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    if (word_q)
      load_data = mem_rdata_i;
    else if (half_q)
      load_data = {{16{!zext_q && half_sel[15]}}, half_sel};
    else
      load_data = {{24{!zext_q && byte_shift[7]}}, byte_shift[7:0]};
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:   if (accept) state_next = misaligned ? RESP : REQ;
      REQ:    if (mem_gnt_i) state_next = store_q ? RESP : WAIT_R;
      WAIT_R: if (mem_rvalid_i) state_next = RESP;
      RESP:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latch the op on accept; capture extended load data on rvalid in WAIT_R.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      store_q <= 1'b0;
      zext_q  <= 1'b0;
      half_q  <= 1'b0;
      word_q  <= 1'b0;
      mis_q   <= 1'b0;
      lane_q  <= '0;
      waddr_q <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else if (accept) begin
      store_q <= is_store_i;
      zext_q  <= funct3_i[2];
      half_q  <= is_half;
      word_q  <= is_word;
      mis_q   <= misaligned;
      lane_q  <= addr_i[1:0];
      waddr_q <= addr_i[31:2];
      be_q    <= be_fmt;
      wdata_q <= wdata_fmt;
      rdata_q <= '0;
    end else if (state == WAIT_R && mem_rvalid_i) begin
      rdata_q <= load_data;
    end
  end

  assign req_ready_o  = (state == IDLE);
  assign mem_req_o    = (state == REQ);
  assign mem_we_o     = (state == REQ) && store_q;
  assign mem_addr_o   = (state == REQ) ? {waddr_q, 2'b00} : '0;
  assign mem_be_o     = (state == REQ) ? be_q : '0;
  assign mem_wdata_o  = (state == REQ) ? wdata_q : '0;
  assign resp_valid_o = (state == RESP);
  assign misaligned_o = (state == RESP) && mis_q;
  assign rdata_o      = (state == RESP) ? rdata_q : '0;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed vector table, hand-written reset
// sequences, and randomized ops checked against an arithmetic model.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        misaligned;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  lsu dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .is_store_i   (is_store),
    .funct3_i     (funct3),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .resp_valid_o (resp_valid),
    .rdata_o      (rdata),
    .misaligned_o (misaligned),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_be_o     (mem_be),
    .mem_wdata_o  (mem_wdata),
    .mem_gnt_i    (mem_gnt),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    int unsigned gd;
    int unsigned rd;
    logic        hold;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rdat;
  } vec_t;

  // Reference model: size in bytes, alignment by modulo, lane by offset.
  task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd_in, input logic [31:0] mr,
                       output logic mis, output logic [3:0] be,
                       output logic [31:0] wd, output logic [31:0] rd);
    int unsigned n, off;
    logic [31:0] v, mask;
    n   = f3[1] ? 4 : (f3[0] ? 2 : 1);
    off = a % 4;
    mis = (a % n) != 0;
    if (st) be = 4'(((1 << n) - 1) << off);
    else    be = 4'hF;
    if (n == 1)      wd = (wd_in & 32'hFF) * 32'h01010101;
    else if (n == 2) wd = (wd_in & 32'hFFFF) * 32'h00010001;
    else             wd = wd_in;
    v = mr >> (8 * off);
    if (n < 4) begin
      mask = (32'd1 << (8 * n)) - 1;
      v = v & mask;
      if (!f3[2] && v[8*n-1]) v = v | ~mask;
    end
    rd = v;
  endtask

  // Run one op from an idle LSU through its response; gd = extra REQ cycles
  // before grant, rd = extra WAIT_R cycles before rvalid.
  task automatic do_op(input vec_t v, input string tag);
    chk({tag, ":ready_before"}, req_ready, 1'b1);
    req_valid = 1'b1; is_store = v.st; funct3 = v.f3; addr = v.addr; wdata = v.wdata;
    @(posedge clk); @(negedge clk);
    if (!v.hold) begin
      req_valid = 1'b0; funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
      is_store = 1'($urandom);
    end
    if (!v.mis) begin
      for (int k = 0; k <= int'(v.gd); k++) begin
        chk({tag, ":mem_req"}, mem_req, 1'b1);
        chk({tag, ":mem_we"}, mem_we, v.st);
        chk({tag, ":mem_addr"}, mem_addr, {v.addr[31:2], 2'b00});
        chk({tag, ":mem_be"}, mem_be, v.be);
        if (v.st) chk({tag, ":mem_wdata"}, mem_wdata, v.wd);
        chk({tag, ":ready_busy"}, req_ready, 1'b0);
        chk({tag, ":resp_early"}, resp_valid, 1'b0);
        mem_gnt = (k == int'(v.gd));
        // A stray rvalid during the grant cycle must be ignored.
        mem_rvalid = (k == int'(v.gd)) && !v.st;
        mem_rdata = ~v.mrdata;
        @(negedge clk);
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (!v.st) begin
        for (int k = 0; k <= int'(v.rd); k++) begin
          chk({tag, ":wait_no_req"}, mem_req, 1'b0);
          chk({tag, ":wait_no_resp"}, resp_valid, 1'b0);
          mem_rvalid = (k == int'(v.rd));
          mem_rdata = (k == int'(v.rd)) ? v.mrdata : $urandom;
          @(negedge clk);
        end
        mem_rvalid = 1'b0;
      end
    end else begin
      chk({tag, ":mis_no_req"}, mem_req, 1'b0);
    end
    chk({tag, ":resp_valid"}, resp_valid, 1'b1);
    chk({tag, ":misaligned"}, misaligned, v.mis);
    chk({tag, ":rdata"}, rdata, (v.st || v.mis) ? 32'h0 : v.rdat);
    req_valid = 1'b0;
    @(negedge clk);
    chk({tag, ":resp_single"}, resp_valid, 1'b0);
    chk({tag, ":ready_after"}, req_ready, 1'b1);
  endtask

  vec_t vecs[12];
  vec_t rv;

  initial begin
    //         st    f3      addr          wdata         mrdata        gd rd hold  mis   be       wd            rdat
    vecs[0]  = '{1'b1, 3'b000, 32'h00001003, 32'h000000A5, 32'h0,        0, 0, 1'b0, 1'b0, 4'b1000, 32'hA5A5A5A5, 32'h0};
    vecs[1]  = '{1'b0, 3'b000, 32'h00002001, 32'h0,        32'h1234F6AA, 0, 0, 1'b0, 1'b0, 4'b1111, 32'h0,        32'hFFFFFFF6};
    vecs[2]  = '{1'b0, 3'b100, 32'h00002001, 32'h0,        32'h1234F6AA, 0, 0, 1'b0, 1'b0, 4'b1111, 32'h0,        32'h000000F6};
    vecs[3]  = '{1'b0, 3'b101, 32'h00002002, 32'h0,        32'h1234F6AA, 0, 1, 1'b0, 1'b0, 4'b1111, 32'h0,        32'h00001234};
    vecs[4]  = '{1'b0, 3'b010, 32'h00003002, 32'h0,        32'h0,        0, 0, 1'b0, 1'b1, 4'b1111, 32'h0,        32'h0};
    vecs[5]  = '{1'b1, 3'b001, 32'h00003001, 32'h0000BEEF, 32'h0,        0, 0, 1'b0, 1'b1, 4'b0010, 32'h0,        32'h0};
    vecs[6]  = '{1'b1, 3'b010, 32'h00004000, 32'hDEADBEEF, 32'h0,        3, 0, 1'b1, 1'b0, 4'b1111, 32'hDEADBEEF, 32'h0};
    vecs[7]  = '{1'b0, 3'b001, 32'h00002000, 32'h0,        32'h1234F6AA, 1, 2, 1'b0, 1'b0, 4'b1111, 32'h0,        32'hFFFFF6AA};
    vecs[8]  = '{1'b1, 3'b001, 32'h00002002, 32'h1234BEEF, 32'h0,        0, 0, 1'b0, 1'b0, 4'b1100, 32'hBEEFBEEF, 32'h0};
    vecs[9]  = '{1'b0, 3'b111, 32'h00005004, 32'h0,        32'h89ABCDEF, 0, 0, 1'b0, 1'b0, 4'b1111, 32'h0,        32'h89ABCDEF};
    vecs[10] = '{1'b0, 3'b000, 32'h00002003, 32'h0,        32'h80000000, 0, 0, 1'b0, 1'b0, 4'b1111, 32'h0,        32'hFFFFFF80};
    vecs[11] = '{1'b1, 3'b000, 32'h00000000, 32'h12345677, 32'h0,        2, 0, 1'b0, 1'b0, 4'b0001, 32'h77777777, 32'h0};

    rst = 1'b1; req_valid = 1'b0; is_store = 1'b0; funct3 = '0; addr = '0; wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    @(negedge clk); @(negedge clk);
    chk("rst:resp_valid", resp_valid, 1'b0);
    chk("rst:mem_req", mem_req, 1'b0);
    chk("rst:mem_we", mem_we, 1'b0);
    chk("rst:misaligned", misaligned, 1'b0);
    chk("rst:rdata", rdata, 32'h0);
    chk("rst:mem_addr", mem_addr, 32'h0);
    chk("rst:mem_be", mem_be, 4'h0);
    chk("rst:mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst:ready_after", req_ready, 1'b1);

    for (int i = 0; i < 12; i++) do_op(vecs[i], $sformatf("vec%0d", i));

    // Reset while waiting for read data; the late rvalid must not respond.
    req_valid = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h00006000;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("rstw:in_wait", mem_req, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstw:ready", req_ready, 1'b1);
    chk("rstw:no_resp", resp_valid, 1'b0);
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("rstw:late_rvalid_resp", resp_valid, 1'b0);
    chk("rstw:late_rvalid_ready", req_ready, 1'b1);
    @(negedge clk);
    chk("rstw:still_idle", resp_valid, 1'b0);
    do_op(vecs[1], "rstw_next");

    // Reset while the request is still waiting for grant.
    req_valid = 1'b1; is_store = 1'b1; funct3 = 3'b010; addr = 32'h00007000; wdata = 32'h11223344;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    chk("rstr:in_req", mem_req, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstr:no_req", mem_req, 1'b0);
    chk("rstr:ready", req_ready, 1'b1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("rstr:no_resp", resp_valid, 1'b0);
    do_op(vecs[0], "rstr_next");

    // Randomized ops against the arithmetic model.
    for (int i = 0; i < 60; i++) begin
      int unsigned n;
      rv.st = 1'($urandom); rv.f3 = 3'($urandom); rv.addr = $urandom;
      rv.wdata = $urandom; rv.mrdata = $urandom;
      rv.gd = $urandom_range(0, 3); rv.rd = $urandom_range(0, 3);
      rv.hold = 1'($urandom);
      n = rv.f3[1] ? 4 : (rv.f3[0] ? 2 : 1);
      if ($urandom_range(0, 3) != 0) rv.addr = rv.addr & ~(n - 1);
      model(rv.st, rv.f3, rv.addr, rv.wdata, rv.mrdata, rv.mis, rv.be, rv.wd, rv.rdat);
      do_op(rv, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
